// File: rtl/cond_wb_unit_pkg.sv
// cond_wb_unit_pkg: shared definitions for the condition/writeback unit.
//   - ARM condition-field encodings (COND_EQ .. COND_AL, COND_NV)
//   - writeback FSM state type (IDLE, ISSUE, HI)
//   - bit positions inside the {Q,N,Z,C,V} ALU flag vector; the same
//     N/Z/C/V positions apply to the 4-bit stored NZCV vector
package cond_wb_unit_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int unsigned FLG_Q = 4;
   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_C = 1;
   localparam int unsigned FLG_V = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HI    = 2'd2
   } wb_state_t;

endpackage

// File: rtl/cond_wb_unit_if.sv
// cond_wb_unit_if: execute-stage flag/result bus into the condition and
// writeback unit, plus the gated strobes and flag state coming back.
//   master : execute stage / ALU side (drives Valid, Cond, ALUFlags, FlagW,
//            PCS, RegW, MemW, NoWrite, LongW, Result, Result2, QClr)
//   slave  : cond_wb_unit (drives PCSrc, RegWrite, MemWrite, WBData,
//            WBSelHi, Busy, CurrCarry, Flags, QFlag)
interface cond_wb_unit_if #(parameter int unsigned DW = 32);

   logic          Valid;
   logic [3:0]    Cond;
   logic [4:0]    ALUFlags;
   logic [1:0]    FlagW;
   logic          PCS;
   logic          RegW;
   logic          MemW;
   logic          NoWrite;
   logic          LongW;
   logic [DW-1:0] Result;
   logic [DW-1:0] Result2;
   logic          QClr;

   logic          PCSrc;
   logic          RegWrite;
   logic          MemWrite;
   logic [DW-1:0] WBData;
   logic          WBSelHi;
   logic          Busy;
   logic          CurrCarry;
   logic [3:0]    Flags;
   logic          QFlag;

   modport master (
      output Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, LongW,
             Result, Result2, QClr,
      input  PCSrc, RegWrite, MemWrite, WBData, WBSelHi, Busy, CurrCarry,
             Flags, QFlag
   );

   modport slave (
      input  Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, LongW,
             Result, Result2, QClr,
      output PCSrc, RegWrite, MemWrite, WBData, WBSelHi, Busy, CurrCarry,
             Flags, QFlag
   );

endinterface

// File: rtl/cond_wb_unit_cond_check.sv
// cond_check: combinational ARM condition evaluation.
//   Cond_i     : 4-bit condition field
//   Nzcv_i     : stored flags {N,Z,C,V}
//   CondTrue_o : 1 when the instruction should execute (NV never executes)
module cond_check
   import cond_wb_unit_pkg::*;
(
   input  logic [3:0] Cond_i,
   input  logic [3:0] Nzcv_i,
   output logic       CondTrue_o
);

   logic n, z, c, v;

   assign n = Nzcv_i[FLG_N];
   assign z = Nzcv_i[FLG_Z];
   assign c = Nzcv_i[FLG_C];
   assign v = Nzcv_i[FLG_V];

   always_comb begin
      CondTrue_o = 1'b0;
      case (Cond_i)
         COND_EQ: CondTrue_o = z;
         COND_NE: CondTrue_o = ~z;
         COND_CS: CondTrue_o = c;
         COND_CC: CondTrue_o = ~c;
         COND_MI: CondTrue_o = n;
         COND_PL: CondTrue_o = ~n;
         COND_VS: CondTrue_o = v;
         COND_VC: CondTrue_o = ~v;
         COND_HI: CondTrue_o = c & ~z;
         COND_LS: CondTrue_o = ~c | z;
         COND_GE: CondTrue_o = (n == v);
         COND_LT: CondTrue_o = (n != v);
         COND_GT: CondTrue_o = ~z & (n == v);
         COND_LE: CondTrue_o = z | (n != v);
         COND_AL: CondTrue_o = 1'b1;
         default: CondTrue_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_wb_unit.sv
// cond_wb_unit: holds NZCV (and optionally sticky Q), gates PC/register/
// memory writes by the condition field, and sequences two-cycle writeback
// of 64-bit results ({Result2, Result}).
//   clk, reset : clock, synchronous active-high reset
//   bus        : cond_wb_unit_if.slave (execute inputs, gated strobes,
//                WBData/WBSelHi, Busy, CurrCarry, Flags, QFlag)
// Optional build macro QFLAG_STICKY_EN: when defined, a sticky Q register is
// kept (set by executed Q results, cleared by QClr, set wins); when
// undefined QFlag is 0 and ALUFlags[4]/QClr are ignored.
module cond_wb_unit
   import cond_wb_unit_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic           clk,
   input  logic           reset,
   cond_wb_unit_if.slave  bus
);

   wb_state_t     state_q;
   logic [3:0]    flags_q;
   logic          long_q;
   logic [DW-1:0] result2_q;
   logic          pcsrc_q;
   logic          regwrite_q;
   logic          memwrite_q;
   logic [DW-1:0] wbdata_q;
   logic          wbselhi_q;

   logic cond_true;
   logic busy;
   logic accept;
   logic cond_ex;
   logic long_d;

   // Condition is judged on the stored flags, never on this cycle's ALU flags.
   cond_check u_cond_check (
      .Cond_i     (bus.Cond),
      .Nzcv_i     (flags_q),
      .CondTrue_o (cond_true)
   );

   assign busy    = (state_q == ISSUE) & long_q;
   assign accept  = bus.Valid & ~busy;
   assign cond_ex = cond_true & accept;
   assign long_d  = bus.LongW & bus.RegW & ~bus.NoWrite & cond_ex;

   // Output registers are loaded on the edge entering a state, so they show
   // the ISSUE/HI values for exactly the cycle spent in that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         flags_q    <= '0;
         long_q     <= 1'b0;
         result2_q  <= '0;
         pcsrc_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memwrite_q <= 1'b0;
         wbdata_q   <= '0;
         wbselhi_q  <= 1'b0;
      end else begin
         if (cond_ex) begin
            if (bus.FlagW[1]) begin
               flags_q[FLG_N] <= bus.ALUFlags[FLG_N];
               flags_q[FLG_Z] <= bus.ALUFlags[FLG_Z];
            end
            if (bus.FlagW[0]) begin
               flags_q[FLG_C] <= bus.ALUFlags[FLG_C];
               flags_q[FLG_V] <= bus.ALUFlags[FLG_V];
            end
         end

         if (busy) begin
            // Second half of a long write; accept is 0 here by construction.
            state_q    <= HI;
            long_q     <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b1;
            memwrite_q <= 1'b0;
            wbdata_q   <= result2_q;
            wbselhi_q  <= 1'b1;
         end else if (accept) begin
            state_q    <= ISSUE;
            long_q     <= long_d;
            result2_q  <= bus.Result2;
            pcsrc_q    <= bus.PCS & cond_ex;
            regwrite_q <= bus.RegW & ~bus.NoWrite & cond_ex;
            memwrite_q <= bus.MemW & cond_ex;
            wbdata_q   <= bus.Result;
            wbselhi_q  <= 1'b0;
         end else begin
            state_q    <= IDLE;
            long_q     <= 1'b0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            wbdata_q   <= '0;
            wbselhi_q  <= 1'b0;
         end
      end
   end

`ifdef QFLAG_STICKY_EN
   logic q_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= 1'b0;
      end else if (cond_ex & bus.ALUFlags[FLG_Q]) begin
         q_q <= 1'b1;
      end else if (bus.QClr) begin
         q_q <= 1'b0;
      end
   end

   assign bus.QFlag = q_q;
`else
   logic unused_q_inputs;
   assign unused_q_inputs = bus.ALUFlags[FLG_Q] ^ bus.QClr;
   assign bus.QFlag = 1'b0;
`endif

   assign bus.PCSrc     = pcsrc_q;
   assign bus.RegWrite  = regwrite_q;
   assign bus.MemWrite  = memwrite_q;
   assign bus.WBData    = wbdata_q;
   assign bus.WBSelHi   = wbselhi_q;
   assign bus.Busy      = busy;
   assign bus.CurrCarry = flags_q[FLG_C];
   assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_cond_wb_unit.sv
// tb_cond_wb_unit: directed, table-driven bench for cond_wb_unit, with
// hand-written sequences for sticky Q and reset in ISSUE/HI.
module tb_cond_wb_unit;

`ifdef QFLAG_STICKY_EN
   localparam logic QEN = 1'b1;
`else
   localparam logic QEN = 1'b0;
`endif

   logic clk;
   logic reset;

   cond_wb_unit_if #(.DW(32)) bus ();

   cond_wb_unit #(.DW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  cond;
      logic [4:0]  aluf;
      logic [1:0]  flagw;
      logic        pcs;
      logic        regw;
      logic        memw;
      logic        nowr;
      logic        longw;
      logic [31:0] res;
      logic [31:0] res2;
      logic        e_pcsrc;
      logic        e_regwr;
      logic        e_memwr;
      logic [31:0] e_wbdata;
      logic        e_selhi;
      logic        e_busy;
      logic [3:0]  e_flags;
   } vec_t;

   vec_t vecs[21];
   int   total;
   int   bad;

   function automatic vec_t mk(
      logic v, logic [3:0] cond, logic [4:0] aluf, logic [1:0] fw,
      logic pcs, logic regw, logic memw, logic nowr, logic lw,
      logic [31:0] res, logic [31:0] res2,
      logic ep, logic er, logic em, logic [31:0] ewb, logic ehi, logic eb,
      logic [3:0] ef);
      vec_t r;
      r.valid = v;     r.cond = cond;   r.aluf = aluf;  r.flagw = fw;
      r.pcs = pcs;     r.regw = regw;   r.memw = memw;  r.nowr = nowr;
      r.longw = lw;    r.res = res;     r.res2 = res2;
      r.e_pcsrc = ep;  r.e_regwr = er;  r.e_memwr = em; r.e_wbdata = ewb;
      r.e_selhi = ehi; r.e_busy = eb;   r.e_flags = ef;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t, input logic qclr);
      bus.Valid    = t.valid;
      bus.Cond     = t.cond;
      bus.ALUFlags = t.aluf;
      bus.FlagW    = t.flagw;
      bus.PCS      = t.pcs;
      bus.RegW     = t.regw;
      bus.MemW     = t.memw;
      bus.NoWrite  = t.nowr;
      bus.LongW    = t.longw;
      bus.Result   = t.res;
      bus.Result2  = t.res2;
      bus.QClr     = qclr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {PCSrc, RegWrite, MemWrite, WBSelHi, Busy, Flags, CurrCarry, QFlag}
   function automatic logic [31:0] ctl_act();
      return {21'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.WBSelHi,
              bus.Busy, bus.Flags, bus.CurrCarry, bus.QFlag};
   endfunction

   function automatic logic [31:0] ctl_exp(logic p, logic r, logic m,
      logic hi, logic b, logic [3:0] f, logic q);
      return {21'd0, p, r, m, hi, b, f, f[1], q};
   endfunction

   initial begin
      vec_t idle_v;
      vec_t t;
      total = 0;
      bad   = 0;

      //            v cond   aluf     fw  pcs regw memw nowr lw  res        res2       ep er em ewb        hi b  flags
      vecs[0]  = mk(1,4'h0,5'b00000,2'd0, 0,1,0,0,0, 32'hAA,    32'h0,     0,0,0,32'hAA,    0,0,4'b0000); // EQ fails
      vecs[1]  = mk(1,4'hE,5'b00110,2'd3, 0,0,0,0,0, 32'h0,     32'h0,     0,0,0,32'h0,     0,0,4'b0110); // flags load
      vecs[2]  = mk(1,4'h1,5'b00000,2'd0, 0,1,0,0,0, 32'h5,     32'h0,     0,0,0,32'h5,     0,0,4'b0110); // NE fails
      vecs[3]  = mk(1,4'hE,5'b00000,2'd0, 0,1,0,0,1, 32'h1111,  32'h2222,  0,1,0,32'h1111,  0,1,4'b0110); // long lo
      vecs[4]  = mk(1,4'hE,5'b00000,2'd3, 0,1,1,0,0, 32'hDEAD,  32'h0,     0,1,0,32'h2222,  1,0,4'b0110); // dropped, long hi
      vecs[5]  = mk(1,4'hE,5'b00000,2'd0, 0,0,1,0,0, 32'h1,     32'h0,     0,0,1,32'h1,     0,0,4'b0110);
      vecs[6]  = mk(1,4'hE,5'b00000,2'd0, 0,0,1,0,0, 32'h2,     32'h0,     0,0,1,32'h2,     0,0,4'b0110);
      vecs[7]  = mk(1,4'hE,5'b00000,2'd0, 0,0,1,0,0, 32'h3,     32'h0,     0,0,1,32'h3,     0,0,4'b0110);
      vecs[8]  = mk(0,4'hE,5'b00000,2'd3, 1,1,1,0,0, 32'h99,    32'h0,     0,0,0,32'h0,     0,0,4'b0110); // not valid
      vecs[9]  = mk(1,4'h8,5'b00000,2'd0, 0,1,0,0,0, 32'h7,     32'h0,     0,0,0,32'h7,     0,0,4'b0110); // HI fails
      vecs[10] = mk(1,4'h9,5'b00001,2'd1, 0,1,0,0,0, 32'h8,     32'h0,     0,1,0,32'h8,     0,0,4'b0101); // LS, CV load
      vecs[11] = mk(1,4'hA,5'b00000,2'd0, 1,1,0,0,0, 32'h9,     32'h0,     0,0,0,32'h9,     0,0,4'b0101); // GE fails
      vecs[12] = mk(1,4'hB,5'b00000,2'd0, 1,1,0,0,0, 32'hA,     32'h0,     1,1,0,32'hA,     0,0,4'b0101); // LT passes
      vecs[13] = mk(1,4'hD,5'b01000,2'd2, 0,1,0,1,0, 32'hB,     32'h0,     0,0,0,32'hB,     0,0,4'b1001); // LE, NoWrite, NZ load
      vecs[14] = mk(1,4'hC,5'b00000,2'd0, 0,0,1,0,0, 32'hC,     32'h0,     0,0,1,32'hC,     0,0,4'b1001); // GT passes
      vecs[15] = mk(1,4'hF,5'b00000,2'd3, 1,1,1,0,0, 32'hF0,    32'h0,     0,0,0,32'hF0,    0,0,4'b1001); // NV never
      vecs[16] = mk(1,4'h4,5'b00000,2'd0, 0,1,0,1,1, 32'hD,     32'h77,    0,0,0,32'hD,     0,0,4'b1001); // long+NoWrite
      vecs[17] = mk(1,4'h3,5'b00000,2'd0, 0,1,0,0,0, 32'hE,     32'h0,     0,1,0,32'hE,     0,0,4'b1001); // CC passes
      vecs[18] = mk(1,4'h6,5'b00000,2'd0, 0,1,0,0,1, 32'h100,   32'h200,   0,1,0,32'h100,   0,1,4'b1001); // VS long lo
      vecs[19] = mk(0,4'h0,5'b00000,2'd0, 0,0,0,0,0, 32'h0,     32'h0,     0,1,0,32'h200,   1,0,4'b1001); // long hi
      vecs[20] = mk(0,4'h0,5'b00000,2'd0, 0,0,0,0,0, 32'h0,     32'h0,     0,0,0,32'h0,     0,0,4'b1001); // back to idle

      idle_v = mk(0,4'h0,5'b0,2'd0, 0,0,0,0,0, 32'h0,32'h0, 0,0,0,32'h0,0,0,4'b0);

      // Reset
      drive(idle_v, 1'b0);
      reset = 1'b1;
      step();
      step();
      check("reset_ctl", ctl_act(), ctl_exp(0,0,0,0,0,4'b0000,1'b0));
      check("reset_wbdata", bus.WBData, 32'h0);
      reset = 1'b0;

      // Table
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i], 1'b0);
         step();
         check($sformatf("vec%0d_ctl", i), ctl_act(),
               ctl_exp(vecs[i].e_pcsrc, vecs[i].e_regwr, vecs[i].e_memwr,
                       vecs[i].e_selhi, vecs[i].e_busy, vecs[i].e_flags, 1'b0));
         check($sformatf("vec%0d_wbdata", i), bus.WBData, vecs[i].e_wbdata);
      end

      // Sticky Q (flags are 1001 here); without the feature QFlag stays 0
      t = mk(1,4'hE,5'b10000,2'd0, 0,0,0,0,0, 32'h0,32'h0, 0,0,0,32'h0,0,0,4'b0);
      drive(t, 1'b0);
      step();
      check("q_set", ctl_act(), ctl_exp(0,0,0,0,0,4'b1001,QEN));
      drive(t, 1'b1);
      step();
      check("q_set_wins_clr", ctl_act(), ctl_exp(0,0,0,0,0,4'b1001,QEN));
      drive(idle_v, 1'b1);
      step();
      check("q_clr", ctl_act(), ctl_exp(0,0,0,0,0,4'b1001,1'b0));
      t.cond = 4'hF;
      drive(t, 1'b0);
      step();
      check("q_cond_fail", ctl_act(), ctl_exp(0,0,0,0,0,4'b1001,1'b0));

      // Reset during HI
      t = mk(1,4'hE,5'b00000,2'd0, 0,1,0,0,1, 32'h33,32'h44, 0,0,0,32'h0,0,0,4'b0);
      drive(t, 1'b0);
      step();
      check("rsthi_issue", ctl_act(), ctl_exp(0,1,0,0,1,4'b1001,1'b0));
      drive(idle_v, 1'b0);
      step();
      check("rsthi_hi", ctl_act(), ctl_exp(0,1,0,1,0,4'b1001,1'b0));
      check("rsthi_hi_data", bus.WBData, 32'h44);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rsthi_after", ctl_act(), ctl_exp(0,0,0,0,0,4'b0000,1'b0));
      check("rsthi_after_data", bus.WBData, 32'h0);

      // Reset during ISSUE of a long write: the high write never appears
      drive(t, 1'b0);
      step();
      check("rstis_issue", ctl_act(), ctl_exp(0,1,0,0,1,4'b0000,1'b0));
      drive(idle_v, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstis_reset", ctl_act(), ctl_exp(0,0,0,0,0,4'b0000,1'b0));
      step();
      check("rstis_no_hi", ctl_act(), ctl_exp(0,0,0,0,0,4'b0000,1'b0));
      check("rstis_no_hi_data", bus.WBData, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
